// File: rtl/nes_bus_pkg.sv
// NES CPU bus shared types: address regions, OAM DMA states and fixed register locations.
// Pure declarations; no timing or flow control.
package nes_bus_pkg;

  typedef enum logic [2:0] {RAM, PPU, OAMDMA, JOY1, JOY2, PRG, NONE} region_t;
  typedef enum logic [2:0] {IDLE, ALIGN, DUMMY, RD, WR} dma_state_t;

  localparam logic [15:0] OAMDMA_ADDR = 16'h4014;
  localparam logic [2:0]  OAMDATA_IDX = 3'd4;

  function automatic region_t decode_region(input logic [15:0] a);
    region_t r;
    r = NONE;
    if (a[15:13] == 3'b000)      r = RAM;
    else if (a[15:13] == 3'b001) r = PPU;
    else if (a == OAMDMA_ADDR)   r = OAMDMA;
    else if (a == 16'h4016)      r = JOY1;
    else if (a == 16'h4017)      r = JOY2;
    else if (a[15])              r = PRG;
    return r;
  endfunction

endpackage

// File: rtl/nes_joypad.sv
// One controller port: strobe latch plus 8-bit serial shift register (1-filled on shift).
// Read bit is combinational from the register; strobe reloads every cycle; no backpressure.
module nes_joypad (
  input  logic       pin_clock,
  input  logic       pin_reset_n,
  input  logic       strobe_w,
  input  logic       strobe_d,
  input  logic       shift,
  input  logic [7:0] buttons,
  output logic       bit0
);

  logic       strobe;
  logic [7:0] sr;

  always_ff @(posedge pin_clock or negedge pin_reset_n) begin
    if (!pin_reset_n) begin
      strobe <= 1'b0;
      sr     <= 8'h00;
    end else begin
      if (strobe_w) strobe <= strobe_d;
      if (strobe)     sr <= buttons;
      else if (shift) sr <= {1'b1, sr[7:1]};
    end
  end

  assign bit0 = sr[0];

endmodule

// File: rtl/nes_cpu_bus.sv
// NES CPU memory-map decoder and OAM DMA engine (joypads under NES_JOYPAD_EN).
// Decode and read data are combinational; DMA stalls the CPU via cpu_ce for 513/514 cycles.
module nes_cpu_bus
  import nes_bus_pkg::*;
#(
  parameter int          PRG_AW   = 15,
  parameter int          RAM_AW   = 11,
  parameter logic [7:0]  OPEN_BUS = 8'h00
) (
  input  logic              pin_clock,
  input  logic              pin_reset_n,
  input  logic [15:0]       cpu_address,
  input  logic [7:0]        cpu_o,
  input  logic              cpu_w,
  input  logic              cpu_read,
  output logic [7:0]        cpu_i,
  output logic              cpu_ce,
  output logic [RAM_AW-1:0] ram_address,
  output logic [7:0]        ram_o,
  output logic              ram_w,
  input  logic [7:0]        ram_i,
  output logic [2:0]        ppu_address,
  output logic [7:0]        ppu_o,
  output logic              ppu_w,
  output logic              ppu_read,
  input  logic [7:0]        ppu_i,
  output logic [PRG_AW-1:0] prg_address,
  input  logic [7:0]        prg_i,
  input  logic [7:0]        joy1,
  input  logic [7:0]        joy2
);

  dma_state_t  state, state_nxt;
  logic        parity;
  logic [7:0]  page, idx, latch;
  logic [15:0] bus_addr;
  logic        bus_w, bus_read, dma_trig;
  region_t     region;
  logic [7:0]  rd_data;

  assign cpu_ce   = (state == IDLE);
  assign dma_trig = cpu_ce & cpu_w & (cpu_address == OAMDMA_ADDR);

  // The DMA engine only becomes bus master while the CPU is stalled.
  assign bus_addr = cpu_ce ? cpu_address : {page, idx};
  assign bus_w    = cpu_ce & cpu_w;
  assign bus_read = cpu_ce ? cpu_read : (state == RD);
  assign region   = decode_region(bus_addr);

  assign ram_address = bus_addr[RAM_AW-1:0];
  assign ram_o       = cpu_o;
  assign ram_w       = bus_w & (region == RAM);
  assign ppu_address = (state == WR) ? OAMDATA_IDX : bus_addr[2:0];
  assign ppu_o       = (state == WR) ? latch : cpu_o;
  assign ppu_w       = (state == WR) | (bus_w & (region == PPU));
  assign ppu_read    = bus_read & (region == PPU);
  assign prg_address = bus_addr[PRG_AW-1:0];

`ifdef NES_JOYPAD_EN
  logic joy1_bit, joy2_bit, joy_strobe_w;

  assign joy_strobe_w = bus_w & (region == JOY1);

  nes_joypad u_joy1 (
    .pin_clock   (pin_clock),
    .pin_reset_n (pin_reset_n),
    .strobe_w    (joy_strobe_w),
    .strobe_d    (cpu_o[0]),
    .shift       (bus_read & (region == JOY1)),
    .buttons     (joy1),
    .bit0        (joy1_bit)
  );

  nes_joypad u_joy2 (
    .pin_clock   (pin_clock),
    .pin_reset_n (pin_reset_n),
    .strobe_w    (joy_strobe_w),
    .strobe_d    (cpu_o[0]),
    .shift       (bus_read & (region == JOY2)),
    .buttons     (joy2),
    .bit0        (joy2_bit)
  );
`else
  logic unused_joy;
  assign unused_joy = ^{joy1, joy2};
`endif

  always_comb begin
    rd_data = OPEN_BUS;
    case (region)
      RAM:     rd_data = ram_i;
      PPU:     rd_data = ppu_i;
      PRG:     rd_data = prg_i;
`ifdef NES_JOYPAD_EN
      JOY1:    rd_data = {7'b0100000, joy1_bit};
      JOY2:    rd_data = {7'b0100000, joy2_bit};
`endif
      default: rd_data = OPEN_BUS;
    endcase
  end

  assign cpu_i = rd_data;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dma_trig) state_nxt = parity ? ALIGN : DUMMY;
      ALIGN:   state_nxt = DUMMY;
      DUMMY:   state_nxt = RD;
      RD:      state_nxt = WR;
      WR:      state_nxt = (idx == 8'hFF) ? IDLE : RD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pin_clock or negedge pin_reset_n) begin
    if (!pin_reset_n) begin
      state  <= IDLE;
      parity <= 1'b0;
      page   <= 8'h00;
      idx    <= 8'h00;
      latch  <= 8'h00;
    end else begin
      state  <= state_nxt;
      parity <= ~parity;
      if (dma_trig) page <= cpu_o;
      if (state == DUMMY)   idx <= 8'h00;
      else if (state == WR) idx <= idx + 8'd1;  // wraps to 0 on the exit write
      if (state == RD) latch <= rd_data;
    end
  end

endmodule

// File: tb/tb_nes_cpu_bus.sv
// Randomized + directed check of nes_cpu_bus against a memory-map reference model.
module tb_nes_cpu_bus;
  localparam logic [7:0] OPEN_BUS = 8'h00;

  logic        pin_clock, pin_reset_n;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_o, cpu_i;
  logic        cpu_w, cpu_read, cpu_ce;
  logic [10:0] ram_address;
  logic [7:0]  ram_o, ram_i;
  logic        ram_w;
  logic [2:0]  ppu_address;
  logic [7:0]  ppu_o, ppu_i;
  logic        ppu_w, ppu_read;
  logic [14:0] prg_address;
  logic [7:0]  prg_i, joy1, joy2;

  logic [7:0] ram_mem [2048];
  int checks = 0;
  int errors = 0;
  int edges;

  nes_cpu_bus #(.PRG_AW(15), .RAM_AW(11), .OPEN_BUS(OPEN_BUS)) dut (
    .pin_clock(pin_clock), .pin_reset_n(pin_reset_n),
    .cpu_address(cpu_address), .cpu_o(cpu_o), .cpu_w(cpu_w), .cpu_read(cpu_read),
    .cpu_i(cpu_i), .cpu_ce(cpu_ce),
    .ram_address(ram_address), .ram_o(ram_o), .ram_w(ram_w), .ram_i(ram_i),
    .ppu_address(ppu_address), .ppu_o(ppu_o), .ppu_w(ppu_w), .ppu_read(ppu_read), .ppu_i(ppu_i),
    .prg_address(prg_address), .prg_i(prg_i),
    .joy1(joy1), .joy2(joy2)
  );

  // Memory stubs: RAM array, PPU register i reads A0+i, PRG byte = low ^ high address bits.
  assign ram_i = ram_mem[ram_address];
  assign ppu_i = 8'hA0 + {5'b0, ppu_address};
  assign prg_i = prg_address[7:0] ^ {1'b0, prg_address[14:8]};

  initial pin_clock = 1'b0;
  always #5 pin_clock = ~pin_clock;

  // Edges since reset release; its parity predicts the DUT's parity bit.
  always @(posedge pin_clock or negedge pin_reset_n)
    if (!pin_reset_n) edges = 0;
    else              edges = edges + 1;

  function automatic logic [7:0] exp_rd(input int a);
    if (a < 'h2000)       return ram_mem[a % 2048];
    else if (a < 'h4000)  return 8'(8'hA0 + (a % 8));
    else if (a >= 'h8000) return 8'(((a - 'h8000) & 255) ^ (((a - 'h8000) >> 8) & 127));
    else                  return OPEN_BUS;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pin_clock);
    #1;
  endtask

  task automatic run_dma(input logic [7:0] pg, input int par,
                         output int stall, output int nwr, output int nbad);
    while ((edges % 2) != par) step();
    cpu_address = 16'h4014; cpu_o = pg; cpu_w = 1'b1; cpu_read = 1'b0;
    step();
    cpu_w = 1'b0; cpu_address = 16'h8000;
    stall = 0; nwr = 0; nbad = 0;
    while (!cpu_ce && stall < 600) begin
      if (ppu_w) begin
        if (ppu_address !== 3'd4 || nwr > 255 || ppu_o !== exp_rd(pg * 256 + nwr)) nbad++;
        nwr++;
      end
      stall++;
      step();
    end
  endtask

  initial begin
    int stall, nwr, nbad, a, wr_n;
    logic [7:0] jv;
    cpu_address = 16'h8000; cpu_o = 8'h00; cpu_w = 1'b0; cpu_read = 1'b0;
    joy1 = 8'b1000_0001; joy2 = 8'($urandom);
    for (int i = 0; i < 2048; i++) ram_mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) ram_mem['h200 + i] = 8'(i);
    ram_mem[1] = 8'h5A;

    pin_reset_n = 1'b0;
    #1;
    chk("rst_cpu_ce", cpu_ce, 1);
    chk("rst_ram_w", ram_w, 0);
    chk("rst_ppu_w", ppu_w, 0);
    chk("rst_ppu_read", ppu_read, 0);
    step(); step();
    pin_reset_n = 1'b1;
    step();

    cpu_address = 16'h0801; cpu_read = 1'b1; #1;
    chk("ram_rd_addr", ram_address, 11'h001);
    chk("ram_rd_data", cpu_i, 8'h5A);
    cpu_address = 16'h1FFF; cpu_read = 1'b0; cpu_w = 1'b1; cpu_o = 8'h33; #1;
    chk("ram_wr_strobe", ram_w, 1);
    chk("ram_wr_addr", ram_address, 11'h7FF);
    chk("ram_wr_data", ram_o, 8'h33);
    step();
    cpu_w = 1'b0; cpu_address = 16'h3FFA; cpu_read = 1'b1; #1;
    chk("ppu_rd_idx", ppu_address, 3'd2);
    chk("ppu_rd_strobe", ppu_read, 1);
    chk("ppu_rd_data", cpu_i, exp_rd('h3FFA));
    cpu_address = 16'h9234; #1;
    chk("prg_addr", prg_address, 15'h1234);
    chk("prg_data", cpu_i, exp_rd('h9234));
    cpu_address = 16'h5000; #1;
    chk("open_bus", cpu_i, OPEN_BUS);
    step();

    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, 'hFFFF));
      if (a == 'h4014 || a == 'h4016 || a == 'h4017) a = 'h0123;
      wr_n = int'($urandom_range(0, 1));
      cpu_address = 16'(a); cpu_o = 8'($urandom);
      cpu_w = (wr_n == 1); cpu_read = (wr_n == 0); #1;
      chk("rnd_rdata", cpu_i, exp_rd(a));
      chk("rnd_ram_w", ram_w, (wr_n == 1) && a < 'h2000);
      chk("rnd_ppu_w", ppu_w, (wr_n == 1) && a >= 'h2000 && a < 'h4000);
      chk("rnd_ppu_read", ppu_read, (wr_n == 0) && a >= 'h2000 && a < 'h4000);
      step();
    end
    cpu_w = 1'b0; cpu_read = 1'b0; cpu_address = 16'h8000;

    run_dma(8'h02, 0, stall, nwr, nbad);
    chk("dma_p0_stall", stall, 513);
    chk("dma_p0_writes", nwr, 256);
    chk("dma_p0_data", nbad, 0);
    chk("dma_p0_ce_back", cpu_ce, 1);
    step(); step(); step();

    run_dma(8'h02, 1, stall, nwr, nbad);
    chk("dma_p1_stall", stall, 514);
    chk("dma_p1_writes", nwr, 256);
    chk("dma_p1_data", nbad, 0);

    while ((edges % 2) != 0) step();
    cpu_address = 16'h4014; cpu_o = 8'h02; cpu_w = 1'b1;
    step();
    cpu_w = 1'b0; cpu_address = 16'h8000;
    repeat (201) step();
    chk("mid_rd_addr", ram_address, 11'h264);
    pin_reset_n = 1'b0; #1;
    chk("mid_rst_ce", cpu_ce, 1);
    chk("mid_rst_ppu_w", ppu_w, 0);
    step();
    pin_reset_n = 1'b1;
    nwr = 0;
    repeat (20) begin
      if (ppu_w) nwr++;
      step();
    end
    chk("post_rst_writes", nwr, 0);
    run_dma(8'h02, 0, stall, nwr, nbad);
    chk("restart_stall", stall, 513);
    chk("restart_writes", nwr, 256);
    chk("restart_data", nbad, 0);

`ifdef NES_JOYPAD_EN
    cpu_address = 16'h4016; cpu_o = 8'h01; cpu_w = 1'b1;
    step();
    cpu_o = 8'h00;
    step();
    cpu_w = 1'b0; cpu_read = 1'b1;
    jv = joy1;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk($sformatf("joy1_read%0d", k), cpu_i, {7'b0100000, (k < 8) ? jv[k] : 1'b1});
      step();
    end
    cpu_address = 16'h4017; jv = joy2; #1;
    chk("joy2_read0", cpu_i, {7'b0100000, jv[0]});
    step();
`else
    cpu_address = 16'h4016; cpu_read = 1'b1; #1;
    chk("joy_open_bus", cpu_i, OPEN_BUS);
    step();
`endif
    cpu_read = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
